firebird7_in_gate1_ijtag_host: RTL and testbench
================================================

FIREBIRD7_IN_GATE1_IJTAG_HOST -- requirements
Module: firebird7_in_gate1_ijtag_host

Interface
REQ-001 The block SHALL have one parameter: MAX_LEN, default 64, the maximum number of shift bits per transaction.
REQ-002 The block SHALL have the port ijtag_tck, input, 1 bit: the single clock; host state uses the posedge, the output drive stage uses the negedge.
REQ-003 The block SHALL have the port ijtag_reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_len (input, 7, shift bit count), cmd_data (input, MAX_LEN, shift-in data, LSB first), cmd_capture (input, 1) and cmd_update (input, 1).
REQ-005 The block SHALL have the ports rsp_valid (output, 1), rsp_ready (input, 1) and rsp_data (output, MAX_LEN, captured scan-out, first bit in [0]).
REQ-006 The block SHALL have the ports ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue and ijtag_si (all output, 1): drives to the target network.
REQ-007 The block SHALL have the port ijtag_so, input, 1 bit: scan-out returned from the network.
REQ-008 The block SHALL have the port txn_count, output, 16 bits: count of completed transactions.

Function
REQ-009 The FSM states SHALL be IDLE, CAPTURE, SHIFT, UPDATE and RESP.
REQ-010 cmd_ready SHALL be 1 only in IDLE; a command is accepted at the posedge where cmd_valid and cmd_ready are both 1.
REQ-011 On acceptance, the next state SHALL be CAPTURE if cmd_capture=1, else SHIFT if the effective length is greater than 0, else UPDATE if cmd_update=1, else RESP.
REQ-012 The effective length SHALL be min(cmd_len, MAX_LEN); cmd_len=0 means no shift cycles.
REQ-013 CAPTURE SHALL last exactly 1 cycle with ce=1 and sel=1.
REQ-014 SHIFT SHALL last exactly the effective length in cycles with se=1.
REQ-015 In SHIFT cycle i (i=0..len-1), ijtag_si SHALL equal cmd_data[i].
REQ-016 In SHIFT, ijtag_so sampled at the posedge ending cycle i SHALL be stored in rsp_data[i]; rsp_data bits at len and above SHALL be 0.
REQ-017 UPDATE SHALL last exactly 1 cycle with ue=1, and only if cmd_update=1.
REQ-018 ijtag_sel SHALL be 1 from CAPTURE/SHIFT/UPDATE entry through UPDATE/SHIFT exit, and 0 in IDLE and RESP.
REQ-019 ce, se and ue SHALL be mutually exclusive.
REQ-020 All ijtag_* outputs SHALL be retimed on the negedge, so they change half a cycle before the target's sampling posedge.
REQ-021 In RESP, rsp_valid SHALL be 1; on rsp_ready=1 the block SHALL return to IDLE the next posedge, and rsp_data SHALL hold stable until then.
REQ-022 Latency: with capture=1, update=1 and length L, rsp_valid SHALL rise L+3 posedges after acceptance.
REQ-023 With rsp_ready held at 0, the block SHALL stay in RESP indefinitely with cmd_ready=0.

Reset
REQ-024 ijtag_reset low SHALL immediately force IDLE; sel, ce, se, ue, si, rsp_valid, rsp_data and txn_count to 0; cmd_ready to 1 after deassertion.
REQ-025 A transaction interrupted by reset SHALL be discarded with no response.

Configuration
REQ-026 With FIREBIRD7_IJTAG_HOST_TXN_COUNT_EN defined, txn_count SHALL increment by 1 on each RESP handshake and saturate at 16'hFFFF.
REQ-027 Without FIREBIRD7_IJTAG_HOST_TXN_COUNT_EN, txn_count SHALL be tied to 0 and the counter logic SHALL be absent.

Structure
REQ-028 Package firebird7_in_gate1_ijtag_host_pkg SHALL hold the state enum, the MAX_LEN default and LEN_W=7.
REQ-029 The negedge output retiming stage SHALL be the sub-module firebird7_in_gate1_ijtag_host_drv.

Verification
REQ-030 Loopback si->so, capture=0, update=0, len=8, data=8'hA5: rsp_data=8'hA5 and no ce/ue pulse.
REQ-031 Single-SIB target with sib reset to 0: len=1, data=1, capture=1, update=1; the target's to_sel goes to 1 after UPDATE, rsp_data[0]=0, and latency is 4 posedges.
REQ-032 len=0, capture=1, update=1: exactly one ce cycle then one ue cycle, se never 1, rsp_data=0.
REQ-033 len=100: exactly 64 se cycles.
REQ-034 rsp_ready held at 0 for 10 cycles: rsp_data is stable and cmd_ready=0.
REQ-035 Reset asserted in SHIFT cycle 3 of 16: all outputs are 0 immediately, no rsp_valid, next command completes normally, and txn_count=1 when the macro is defined.

Source files
------------

// File: rtl/firebird7_in_gate1_ijtag_host_pkg.sv
// Shared types and constants for the firebird7 IJTAG host.
package firebird7_in_gate1_ijtag_host_pkg;

    localparam int MAX_LEN_DEF = 64;
    localparam int LEN_W       = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        RESP    = 3'd4
    } state_e;

    // Requested shift count clipped to the width of the data registers.
    function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] len, input int max_len);
        if (int'(len) > max_len) return LEN_W'(max_len);
        return len;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_ijtag_host_drv.sv
// Negedge retiming stage for the IJTAG drives, so the target sees stable
// levels half a cycle before its sampling posedge.
module firebird7_in_gate1_ijtag_host_drv (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sel_i,
    input  logic ce_i,
    input  logic se_i,
    input  logic ue_i,
    input  logic si_i,
    output logic sel_o,
    output logic ce_o,
    output logic se_o,
    output logic ue_o,
    output logic si_o
);

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_o <= 1'b0;
            ce_o  <= 1'b0;
            se_o  <= 1'b0;
            ue_o  <= 1'b0;
            si_o  <= 1'b0;
        end else begin
            sel_o <= sel_i;
            ce_o  <= ce_i;
            se_o  <= se_i;
            ue_o  <= ue_i;
            si_o  <= si_i;
        end
    end

endmodule

// File: rtl/firebird7_in_gate1_ijtag_host.sv
// IJTAG host: runs one capture/shift/update transaction per command.
// Optional saturating transaction counter: FIREBIRD7_IJTAG_HOST_TXN_COUNT_EN.
module firebird7_in_gate1_ijtag_host
    import firebird7_in_gate1_ijtag_host_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    input  logic               cmd_capture,
    input  logic               cmd_update,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               ijtag_sel,
    output logic               ijtag_ce,
    output logic               ijtag_se,
    output logic               ijtag_ue,
    output logic               ijtag_si,
    input  logic               ijtag_so,
    output logic [15:0]        txn_count
);

    state_e             state_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] mask_q;
    logic [MAX_LEN-1:0] rsp_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               update_q;
    logic [LEN_W-1:0]   eff_len;

    assign eff_len = clip_len(cmd_len, MAX_LEN);

    // data_q shifts out LSB first; mask_q is a one-hot pointer to the rsp bit being filled.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            rsp_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            update_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        data_q   <= cmd_data;
                        mask_q   <= MAX_LEN'(1);
                        rsp_q    <= '0;
                        len_q    <= eff_len;
                        cnt_q    <= '0;
                        update_q <= cmd_update;
                        if (cmd_capture)          state_q <= CAPTURE;
                        else if (eff_len != '0)   state_q <= SHIFT;
                        else if (cmd_update)      state_q <= UPDATE;
                        else                      state_q <= RESP;
                    end
                end
                CAPTURE: begin
                    if (len_q != '0)   state_q <= SHIFT;
                    else if (update_q) state_q <= UPDATE;
                    else               state_q <= RESP;
                end
                SHIFT: begin
                    data_q <= data_q >> 1;
                    mask_q <= mask_q << 1;
                    if (ijtag_so) rsp_q <= rsp_q | mask_q;
                    cnt_q  <= cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) state_q <= update_q ? UPDATE : RESP;
                end
                UPDATE: state_q <= RESP;
                RESP: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_q;

    firebird7_in_gate1_ijtag_host_drv u_drv (
        .clk_i  (ijtag_tck),
        .rst_ni (ijtag_reset),
        .sel_i  ((state_q == CAPTURE) || (state_q == SHIFT) || (state_q == UPDATE)),
        .ce_i   (state_q == CAPTURE),
        .se_i   (state_q == SHIFT),
        .ue_i   (state_q == UPDATE),
        .si_i   ((state_q == SHIFT) && data_q[0]),
        .sel_o  (ijtag_sel),
        .ce_o   (ijtag_ce),
        .se_o   (ijtag_se),
        .ue_o   (ijtag_ue),
        .si_o   (ijtag_si)
    );

`ifdef FIREBIRD7_IJTAG_HOST_TXN_COUNT_EN
    logic [15:0] txn_q;

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            txn_q <= '0;
        end else if ((state_q == RESP) && rsp_ready && (txn_q != 16'hFFFF)) begin
            txn_q <= txn_q + 16'd1;
        end
    end

    assign txn_count = txn_q;
`else
    assign txn_count = 16'h0000;
`endif

endmodule

// File: tb/tb_firebird7_in_gate1_ijtag_host.sv
// Directed bench for the firebird7 IJTAG host with a loopback / single-SIB target.
module tb_firebird7_in_gate1_ijtag_host;

`ifdef FIREBIRD7_IJTAG_HOST_TXN_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_len;
    logic [63:0] cmd_data;
    logic        cmd_capture;
    logic        cmd_update;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, ijtag_so;
    logic [15:0] txn_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_txn  = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    firebird7_in_gate1_ijtag_host dut (
        .ijtag_tck   (clk),
        .ijtag_reset (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .cmd_data    (cmd_data),
        .cmd_capture (cmd_capture),
        .cmd_update  (cmd_update),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .ijtag_sel   (ijtag_sel),
        .ijtag_ce    (ijtag_ce),
        .ijtag_se    (ijtag_se),
        .ijtag_ue    (ijtag_ue),
        .ijtag_si    (ijtag_si),
        .ijtag_so    (ijtag_so),
        .txn_count   (txn_count)
    );

    // ---------------- target network model ----------------
    logic sib_mode;
    logic sib_sr;
    logic to_sel;

    assign ijtag_so = sib_mode ? sib_sr : ijtag_si;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sib_sr <= 1'b0;
            to_sel <= 1'b0;
        end else if (ijtag_sel) begin
            if (ijtag_ce) sib_sr <= to_sel;
            if (ijtag_se) sib_sr <= ijtag_si;
            if (ijtag_ue) to_sel <= sib_sr;
        end
    end

    // ---------------- pulse monitors ----------------
    int ce_cnt = 0, se_cnt = 0, ue_cnt = 0, viol_cnt = 0;

    always @(posedge clk) begin
        if (ijtag_ce) ce_cnt++;
        if (ijtag_se) se_cnt++;
        if (ijtag_ue) ue_cnt++;
        if ((int'(ijtag_ce) + int'(ijtag_se) + int'(ijtag_ue)) > 1) viol_cnt++;
        if ((ijtag_ce || ijtag_se || ijtag_ue) && !ijtag_sel) viol_cnt++;
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] len, input logic [63:0] data, input logic cap, input logic upd);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_len     = len;
        cmd_data    = data;
        cmd_capture = cap;
        cmd_update  = upd;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Latency counts posedges from the accepting edge (inclusive) to the one raising rsp_valid.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_txn++;
    endtask

    function automatic logic [15:0] exp_count();
        return CNT_EN ? 16'(exp_txn) : 16'h0;
    endfunction

    // ---------------- directed sequence ----------------
    int lat, ce0, se0, ue0;

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_len     = '0;
        cmd_data    = '0;
        cmd_capture = 1'b0;
        cmd_update  = 1'b0;
        rsp_ready   = 1'b0;
        sib_mode    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_drives", {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 0);
        check("reset_txn_count", txn_count, 0);

        // Loopback, 8 bits, no capture/update
        ce0 = ce_cnt; se0 = se_cnt; ue0 = ue_cnt;
        issue(7'd8, 64'hA5, 1'b0, 1'b0);
        wait_rsp(lat);
        check("lb8_rsp_valid", rsp_valid, 1);
        check("lb8_latency", lat, 9);
        check("lb8_rsp_data", rsp_data, 64'hA5);
        check("lb8_ce_pulses", ce_cnt - ce0, 0);
        check("lb8_ue_pulses", ue_cnt - ue0, 0);
        check("lb8_se_pulses", se_cnt - se0, 8);
        check("lb8_cmd_ready_busy", cmd_ready, 0);
        @(negedge clk); #1;
        check("lb8_sel_in_resp", ijtag_sel, 0);
        ack();
        check("lb8_cmd_ready_idle", cmd_ready, 1);
        check("lb8_txn_count", txn_count, exp_count());

        // Loopback, 16 bits; data above len must not leak into rsp_data
        issue(7'd16, 64'hFFFF_0000_0000_3C5A, 1'b0, 1'b0);
        wait_rsp(lat);
        check("lb16_rsp_data", rsp_data, 64'h3C5A);
        // Hold the response for 10 cycles with rsp_ready low
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_rsp_data", rsp_data, 64'h3C5A);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rsp_valid", rsp_valid, 1);
        end
        ack();
        check("lb16_txn_count", txn_count, exp_count());

        // Single SIB: open it
        sib_mode = 1'b1;
        ce0 = ce_cnt; se0 = se_cnt; ue0 = ue_cnt;
        issue(7'd1, 64'h1, 1'b1, 1'b1);
        wait_rsp(lat);
        check("sib_open_latency", lat, 4);
        check("sib_open_rsp_data", rsp_data, 0);
        check("sib_open_to_sel", to_sel, 1);
        check("sib_open_ce", ce_cnt - ce0, 1);
        check("sib_open_se", se_cnt - se0, 1);
        check("sib_open_ue", ue_cnt - ue0, 1);
        ack();

        // Single SIB: close it, capture must return the open state
        issue(7'd1, 64'h0, 1'b1, 1'b1);
        wait_rsp(lat);
        check("sib_close_rsp_data", rsp_data, 1);
        check("sib_close_to_sel", to_sel, 0);
        ack();
        sib_mode = 1'b0;

        // Zero length with capture and update
        ce0 = ce_cnt; se0 = se_cnt; ue0 = ue_cnt;
        issue(7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        wait_rsp(lat);
        check("len0_latency", lat, 3);
        check("len0_ce", ce_cnt - ce0, 1);
        check("len0_se", se_cnt - se0, 0);
        check("len0_ue", ue_cnt - ue0, 1);
        check("len0_rsp_data", rsp_data, 0);
        ack();

        // Over-length command clipped to 64
        se0 = se_cnt;
        issue(7'd100, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        wait_rsp(lat);
        check("len100_latency", lat, 65);
        check("len100_se", se_cnt - se0, 64);
        check("len100_rsp_data", rsp_data, 64'h0123_4567_89AB_CDEF);
        ack();
        check("pre_reset_txn_count", txn_count, exp_count());

        // Reset during SHIFT cycle 3 of 16
        issue(7'd16, 64'hBEEF, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("mid_shift_se", ijtag_se, 1);
        check("mid_shift_sel", ijtag_sel, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_drives", {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_rsp_data", rsp_data, 0);
        check("async_rst_txn_count", txn_count, 0);
        exp_txn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        check("post_rst_cmd_ready", cmd_ready, 1);

        issue(7'd4, 64'h9, 1'b0, 1'b0);
        wait_rsp(lat);
        check("after_rst_rsp_valid", rsp_valid, 1);
        check("after_rst_rsp_data", rsp_data, 64'h9);
        ack();
        check("after_rst_txn_count", txn_count, exp_count());

        check("drive_exclusivity", viol_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
